// File: rtl/seven_seg_scan.sv
// seven_seg_scan: scans a 16-bit hex value across four active-low digits with per-slot blanking; LEADING_ZERO_BLANK_EN hides leading zero digits.
module seven_seg_scan #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  binary,
  output logic        dp,
  output logic        enable0,
  output logic        enable1,
  output logic        enable2,
  output logic        enable3,
  output logic [1:0]  digit_sel,
  output logic        frame_start
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_TICKS);
  logic          run_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   val_q, val_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [3:0]    en_q, en_d, bin_q, bin_d;
  logic          dp_q, dp_d, fs_q, load, show;
  // The first edge after reset enters slot 0 / count 0 rather than advancing.
  always_comb begin
    cnt_d = !run_q ? '0 : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    sel_d = !run_q ? 2'd0 : (cnt_q == LAST) ? sel_q + 2'd1 : sel_q;
    load  = (cnt_d == '0) && (sel_d == 2'd0);
    val_d = load ? value : val_q;
    sdp_d = load ? dp_in : sdp_q;
`ifdef LEADING_ZERO_BLANK_EN
    show  = (cnt_d >= BLANK) && !((sel_d != 2'd0) && ((val_d >> {sel_d, 2'b00}) == 16'd0));
`else
    show  = cnt_d >= BLANK;
`endif
    en_d  = show ? ~(4'b0001 << sel_d) : 4'hf;
    dp_d  = ~(show & sdp_d[sel_d]);
    bin_d = val_d[{sel_d, 2'b00} +: 4];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      sel_q <= 2'd0;
      val_q <= 16'd0;
      sdp_q <= 4'd0;
      en_q  <= 4'hf;
      bin_q <= 4'd0;
      dp_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      val_q <= val_d;
      sdp_q <= sdp_d;
      en_q  <= en_d;
      bin_q <= bin_d;
      dp_q  <= dp_d;
      fs_q  <= load;
    end
  end
  assign {enable3, enable2, enable1, enable0} = en_q;
  assign binary      = bin_q;
  assign dp          = dp_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: random and directed stimulus checked every cycle against an edge-count model of the scanner.
module tb_seven_seg_scan;
  localparam int T = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * T;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] value = 16'h1234;
  logic [3:0] dp_in = 4'd0;
  logic [3:0] binary, en;
  logic dp, enable0, enable1, enable2, enable3, frame_start;
  logic [1:0] digit_sel;
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  logic [15:0] sv = 16'd0;
  logic [3:0] sd = 4'd0;

  seven_seg_scan #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .binary(binary), .dp(dp),
    .enable0(enable0), .enable1(enable1), .enable2(enable2), .enable3(enable3),
    .digit_sel(digit_sel), .frame_start(frame_start)
  );
  assign en = {enable3, enable2, enable1, enable0};

  always #5 clk = ~clk;

  // n counts edges since reset release; a frame is loaded on every edge with n % FRAME == 0 before counting it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n  <= 0;
      sv <= 16'd0;
      sd <= 4'd0;
    end else begin
      n <= n + 1;
      if (n % FRAME == 0) begin
        sv <= value;
        sd <= dp_in;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, n);
    end
  endtask

  always @(negedge clk) begin
    int p, d, c;
    logic show;
    logic [3:0] e_en, e_bin;
    logic e_dp, e_fs;
    logic [1:0] e_sel;
    if (n == 0) begin
      e_en = 4'hf; e_dp = 1'b1; e_bin = 4'd0; e_sel = 2'd0; e_fs = 1'b0;
    end else begin
      p = (n - 1) % FRAME;
      d = p / T;
      c = p % T;
      show = c >= B;
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && (sv >> (4 * d)) == 16'd0) show = 1'b0;
`endif
      e_en  = show ? 4'hf ^ 4'(1 << d) : 4'hf;
      e_dp  = !(show && sd[d]);
      e_bin = 4'((sv >> (4 * d)) & 16'hf);
      e_sel = 2'(d);
      e_fs  = p == 0;
    end
    chk("enables", 16'(en), 16'(e_en));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("binary", 16'(binary), 16'(e_bin));
    chk("digit_sel", 16'(digit_sel), 16'(e_sel));
    chk("frame_start", 16'(frame_start), 16'(e_fs));
  end

  task automatic wait_n(input int k);
    for (int i = 0; i < 4000 && n != k; i++) @(negedge clk);
    if (n != k) begin
      mismatched++;
      $display("FAIL wait_n: got edge %0d expected %0d", n, k);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_reset_en", 16'(en), 16'hf);
    chk("lit_reset_dp", 16'(dp), 16'h1);
    chk("lit_reset_bin", 16'(binary), 16'h0);
    reset = 1'b0;
    wait_n(1);
    chk("lit_fs_edge1", 16'(frame_start), 16'h1);
    chk("lit_en_edge1", 16'(en), 16'hf);
    chk("lit_bin_edge1", 16'(binary), 16'h4);
    wait_n(2);
    chk("lit_fs_edge2", 16'(frame_start), 16'h0);
    wait_n(3);
    chk("lit_en0_edge3", 16'(en), 16'he);
    wait_n(8);
    chk("lit_en0_edge8", 16'(en), 16'he);
    wait_n(9);
    chk("lit_en_edge9", 16'(en), 16'hf);
    chk("lit_bin_edge9", 16'(binary), 16'h3);
    chk("lit_sel_edge9", 16'(digit_sel), 16'h1);
    wait_n(11);
    chk("lit_en1_edge11", 16'(en), 16'hd);
    wait_n(12);
    value = 16'hABCD;
    wait_n(19);
    chk("lit_bin_edge19", 16'(binary), 16'h2);
    chk("lit_en2_edge19", 16'(en), 16'hb);
    wait_n(27);
    chk("lit_bin_edge27", 16'(binary), 16'h1);
    chk("lit_en3_edge27", 16'(en), 16'h7);
    wait_n(33);
    chk("lit_fs_edge33", 16'(frame_start), 16'h1);
    chk("lit_bin_edge33", 16'(binary), 16'hd);
    wait_n(40);
    dp_in = 4'b0100;
    wait_n(41);
    chk("lit_bin_edge41", 16'(binary), 16'hc);
    wait_n(83);
    chk("lit_dp_edge83", 16'(dp), 16'h0);
    chk("lit_en_edge83", 16'(en), 16'hb);
    wait_n(89);
    chk("lit_dp_edge89", 16'(dp), 16'h1);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        value = 16'($urandom);
        dp_in = 4'($urandom);
      end
    end
    for (int i = 0; i < 64 && ((n - 1) % FRAME) != 2 * T + 4; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("lit_async_en", 16'(en), 16'hf);
    chk("lit_async_dp", 16'(dp), 16'h1);
    chk("lit_async_bin", 16'(binary), 16'h0);
    chk("lit_async_sel", 16'(digit_sel), 16'h0);
    repeat (2) @(negedge clk);
    value = 16'h1234;
    dp_in = 4'd0;
    reset = 1'b0;
    wait_n(1);
    chk("lit_restart_fs", 16'(frame_start), 16'h1);
    chk("lit_restart_bin", 16'(binary), 16'h4);
    value = 16'h0005;
    wait_n(59);
    chk("lit_0005_bin3", 16'(binary), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit_0005_en3", 16'(en), 16'hf);
`else
    chk("lit_0005_en3", 16'(en), 16'h7);
`endif
    value = 16'h0105;
    wait_n(83);
    chk("lit_0105_en2", 16'(en), 16'hb);
    wait_n(91);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit_0105_en3", 16'(en), 16'hf);
`else
    chk("lit_0105_en3", 16'(en), 16'h7);
`endif
    value = 16'h0000;
    wait_n(99);
    chk("lit_0000_en0", 16'(en), 16'he);
    wait_n(107);
    chk("lit_0000_bin1", 16'(binary), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit_0000_en1", 16'(en), 16'hf);
`else
    chk("lit_0000_en1", 16'(en), 16'hd);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexes a 16-bit hex value onto the Basys3 4-digit common-anode display.
- Sits directly upstream of the single-digit seven-segment decoder:
  - feeds the decoder's 4-bit binary input one nibble at a time;
  - drives the four active-low digit enables and the active-low decimal point.
- Inserts a blanking interval before each digit to suppress ghosting.
- Latches the displayed value once per frame to prevent tearing.

Parameters:
- TICKS_PER_DIGIT, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be > BLANK_TICKS.
- BLANK_TICKS, 1000, cycles at the start of each slot with all digits disabled; must be >= 1.

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-high reset
- value  input  16  hex value to display; nibble k goes to digit k (digit 0 = rightmost)
- dp_in  input  4  decimal point request per digit, active-high
- binary  output  4  nibble for the current digit, to the decoder's binary input
- dp  output  1  decimal point, active-low
- enable0  output  1  digit 0 enable, active-low
- enable1  output  1  digit 1 enable, active-low
- enable2  output  1  digit 2 enable, active-low
- enable3  output  1  digit 3 enable, active-low
- digit_sel  output  2  index of the current slot
- frame_start  output  1  one-cycle pulse when a new frame begins and the shadow registers load

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high; all registers clear immediately on assertion.
- Reset values:
  - enable0..3 = 1, dp = 1, binary = 0, digit_sel = 0, frame_start = 0.
  - Shadow value = 0, shadow dp = 0, slot counter = 0.
- Slot counter cnt runs 0..TICKS_PER_DIGIT-1, then wraps to 0. On wrap, digit_sel increments modulo 4 (3 -> 0).
- Counter width is the minimum needed to hold TICKS_PER_DIGIT-1.
- Edge numbering: edge 1 is the first rising edge with reset low. Slot for digit d occupies TICKS_PER_DIGIT consecutive edges.
- All outputs are registered. At each edge, outputs reflect the cnt/digit value being entered on that edge.
- Blank phase (cnt < BLANK_TICKS):
  - all enables = 1, dp = 1;
  - binary = shadow nibble for digit_sel, updated on the first blank edge of the slot so it is stable before the enable asserts.
- On phase (cnt >= BLANK_TICKS):
  - enable[digit_sel] = 0, other enables = 1;
  - dp = ~shadow_dp[digit_sel].
- Frame load, on the first edge of digit 0's slot (including edge 1 after reset):
  - shadow value <= value, shadow dp <= dp_in;
  - frame_start = 1 for exactly that cycle.
- value/dp_in changes at any other time have no visible effect until the next frame load.
- Timing: each enable is low for exactly TICKS_PER_DIGIT-BLANK_TICKS cycles per frame. Frame length = 4*TICKS_PER_DIGIT cycles.
- At most one enable is low in any cycle. No enable is low on the cycle where digit_sel changes.
- Reset mid-slot: outputs return to reset values asynchronously. After release, scanning restarts at digit 0, cnt 0, with a fresh frame load.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - during the on phase of digit d (d = 1..3), enable[d] stays 1 if shadow nibbles d..3 are all zero;
  - digit 0 is always shown;
  - dp follows the same suppression;
  - slot timing, binary, digit_sel and frame_start are unchanged.
- Undefined: all four digits always display, including leading zeros.

Test Plan (TICKS_PER_DIGIT=8, BLANK_TICKS=2):
- Reset, then release:
  - during reset: enables=4'b1111, dp=1, binary=0;
  - frame_start high after edge 1;
  - enable0 low after edges 3..8 (6 cycles), high after edge 9.
- value=16'h1234, dp_in=0, over one frame:
  - binary = 4, 3, 2, 1 in digits 0..3;
  - each enable low 6 cycles after 2 blank cycles;
  - frame_start every 32 cycles; dp always 1.
- value changes 16'h1234 -> 16'hABCD during digit 1's slot:
  - digits 2 and 3 still show 2, 1;
  - next frame shows D, C, B, A.
- dp_in=4'b0100: dp=0 only during digit 2's on phase (6 cycles per frame).
- reset asserted during digit 2's on phase: enable2 returns to 1 without waiting for a clock edge; after release, digit 0 slot restarts with a frame load.
- LEADING_ZERO_BLANK_EN defined:
  - value=16'h0005: only enable0 ever goes low;
  - value=16'h0105: enable0, enable1 and enable2 go low, enable3 stays 1;
  - value=16'h0000: enable0 only, binary=0.
